// File: rtl/y86_pkg.sv
// Shared types for the y86 memory arbiter: FSM states, default bus widths
// and the request payload steered onto the memory port.
package y86_pkg;

    localparam int unsigned Y86_AW = 32;
    localparam int unsigned Y86_DW = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef struct packed {
        logic [Y86_AW-1:0] addr;
        logic [Y86_DW-1:0] wdata;
        logic              re;
        logic              we;
    } bus_req_t;

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Bundle of core bus, host handshake and memory port signals around the arbiter.
interface y86_mem_arbiter_if #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
);

    logic [AW-1:0]    cpu_A;
    logic             cpu_RE;
    logic             cpu_WE;
    logic [DW-1:0]    cpu_wdata;
    logic [DW-1:0]    cpu_rdata;

    logic             host_valid;
    logic             host_ready;
    logic             host_we;
    logic [AW-1:0]    host_addr;
    logic [DW-1:0]    host_wdata;
    logic             host_rvalid;
    logic [DW-1:0]    host_rdata;

    logic [AW-1:0]    mem_A;
    logic             mem_RE;
    logic             mem_WE;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;

    logic             host_starved;
    logic [CNT_W-1:0] host_wait_max;

    // Arbiter side
    modport slave (
        input  cpu_A, cpu_RE, cpu_WE, cpu_wdata,
        input  host_valid, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_rdata, host_ready, host_rvalid, host_rdata,
        output mem_A, mem_RE, mem_WE, mem_wdata,
        output host_starved, host_wait_max
    );

    // Requesters and memory side
    modport master (
        output cpu_A, cpu_RE, cpu_WE, cpu_wdata,
        output host_valid, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_rdata, host_ready, host_rvalid, host_rdata,
        input  mem_A, mem_RE, mem_WE, mem_wdata,
        input  host_starved, host_wait_max
    );

endinterface

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module y86_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/y86_mem_arbiter.sv
// Single-port memory arbiter: the y86 core always wins, the host port is
// granted in core-idle cycles and its wait time is tracked for starvation.
module y86_mem_arbiter
    import y86_pkg::*;
#(
    parameter int unsigned AW           = Y86_AW,
    parameter int unsigned DW           = Y86_DW,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    y86_mem_arbiter_if.slave     bus
);

    logic             cpu_busy;
    logic             accept;
    logic             wait_inc;
    logic             wait_clr;
    logic             starve_hit;
    logic [CNT_W-1:0] wcnt;
    bus_req_t         req;

    arb_state_e       state_q;
    logic             host_rvalid_q;
    logic [DW-1:0]    host_rdata_q;
    logic             host_starved_q;
    logic [CNT_W-1:0] host_wait_max_q;

    assign cpu_busy       = bus.cpu_RE | bus.cpu_WE;
    assign bus.host_ready = bus.host_valid & ~cpu_busy & ~rst;
    assign accept         = bus.host_ready;
    assign bus.cpu_rdata  = bus.mem_rdata;

    // Memory port steering: core, then granted host, otherwise quiet bus
    always_comb begin
        req = '0;
        if (cpu_busy) begin
            req.addr  = Y86_AW'(bus.cpu_A);
            req.wdata = Y86_DW'(bus.cpu_wdata);
            req.re    = bus.cpu_RE;
            req.we    = bus.cpu_WE;
        end else if (accept) begin
            req.addr  = Y86_AW'(bus.host_addr);
            req.wdata = Y86_DW'(bus.host_wdata);
            req.re    = ~bus.host_we;
            req.we    = bus.host_we;
        end
    end

    assign bus.mem_A     = AW'(req.addr);
    assign bus.mem_wdata = DW'(req.wdata);
    assign bus.mem_RE    = req.re;
    assign bus.mem_WE    = req.we;

    // A withdrawn request also clears the count, so a violation leaves no trace
    assign wait_inc = bus.host_valid & ~bus.host_ready;
    assign wait_clr = bus.host_ready | ~bus.host_valid;

    y86_sat_counter #(
        .W (CNT_W)
    ) u_wcnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wait_inc),
        .clr_i   (wait_clr),
        .count_o (wcnt)
    );

    // Flag rises on the same edge the count reaches the limit
    assign starve_hit = (32'(wcnt) >= STARVE_LIMIT) ||
                        (wait_inc && ((32'(wcnt) + 32'd1) == STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            case (state_q)
                ARB_IDLE: if (bus.host_valid && cpu_busy)      state_q <= ARB_WAIT;
                ARB_WAIT: if (accept || !bus.host_valid)       state_q <= ARB_IDLE;
                default:                                       state_q <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host_rvalid_q   <= 1'b0;
            host_rdata_q    <= '0;
            host_starved_q  <= 1'b0;
            host_wait_max_q <= '0;
        end else begin
            host_rvalid_q <= accept & ~bus.host_we;
            if (accept && !bus.host_we) begin
                host_rdata_q <= bus.mem_rdata;
            end
            if (starve_hit) begin
                host_starved_q <= 1'b1;
            end
            if (accept && (wcnt > host_wait_max_q)) begin
                host_wait_max_q <= wcnt;
            end
        end
    end

    assign bus.host_rvalid   = host_rvalid_q;
    assign bus.host_rdata    = host_rdata_q;
    assign bus.host_starved  = host_starved_q;
    assign bus.host_wait_max = host_wait_max_q;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter with a small combinational-read memory.
module tb_y86_mem_arbiter;

    logic clk;
    logic rst;
    logic preload;
    int   checks;
    int   errors;

    logic [31:0] mem [0:255];

    y86_mem_arbiter_if #(.AW(32), .DW(32), .CNT_W(16)) bus ();

    y86_mem_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (4),
        .CNT_W        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_A[7:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h00] <= 32'h1111_1111;
            mem[8'h04] <= 32'h2222_2222;
            mem[8'h10] <= 32'hDEAD_BEEF;
        end else if (bus.mem_WE) begin
            mem[bus.mem_A[7:0]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_A      = '0;
        bus.cpu_RE     = 1'b0;
        bus.cpu_WE     = 1'b0;
        bus.cpu_wdata  = '0;
        bus.host_valid = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        preload = 1'b1;
        rst     = 1'b1;
        idle_inputs();
        tick();
        preload = 1'b0;

        // Reset: core passthrough live, host grant blocked
        bus.cpu_WE     = 1'b1;
        bus.cpu_A      = 32'hF0;
        bus.cpu_wdata  = 32'h3;
        bus.host_valid = 1'b1;
        bus.host_addr  = 32'h10;
        #1;
        chk("rst_mem_WE", 32'(bus.mem_WE), 32'd1);
        chk("rst_mem_A", bus.mem_A, 32'hF0);
        chk("rst_host_ready", 32'(bus.host_ready), 32'd0);
        tick();
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("reset_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("reset_rdata", bus.host_rdata, 32'h0);
        chk("reset_starved", 32'(bus.host_starved), 32'd0);
        chk("reset_wait_max", 32'(bus.host_wait_max), 32'd0);
        chk("idle_mem_A", bus.mem_A, 32'h0);
        chk("idle_mem_RE", 32'(bus.mem_RE), 32'd0);
        tick();

        // Uncontended read
        bus.host_valid = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = 32'h10;
        #1;
        chk("rd_ready", 32'(bus.host_ready), 32'd1);
        chk("rd_mem_RE", 32'(bus.mem_RE), 32'd1);
        chk("rd_mem_A", bus.mem_A, 32'h10);
        tick();
        bus.host_valid = 1'b0;
        chk("rd_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("rd_rdata", bus.host_rdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_rvalid_drop", 32'(bus.host_rvalid), 32'd0);
        chk("rd_rdata_hold", bus.host_rdata, 32'hDEAD_BEEF);

        // Contended write: core reads three cycles
        bus.cpu_RE     = 1'b1;
        bus.cpu_A      = 32'h40;
        bus.host_valid = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 32'h20;
        bus.host_wdata = 32'h55AA;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("cw_ready_low", 32'(bus.host_ready), 32'd0);
            chk("cw_mem_A_cpu", bus.mem_A, 32'h40);
            tick();
        end
        bus.cpu_RE = 1'b0;
        #1;
        chk("cw_ready", 32'(bus.host_ready), 32'd1);
        chk("cw_mem_WE", 32'(bus.mem_WE), 32'd1);
        chk("cw_mem_A_host", bus.mem_A, 32'h20);
        tick();
        bus.host_valid = 1'b0;
        chk("cw_wait_max", 32'(bus.host_wait_max), 32'd3);
        chk("cw_mem_written", mem[8'h20], 32'h55AA);
        chk("cw_no_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("cw_not_starved", 32'(bus.host_starved), 32'd0);

        // Starvation: six blocked cycles with limit four
        bus.cpu_RE     = 1'b1;
        bus.cpu_A      = 32'h44;
        bus.host_valid = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = 32'h10;
        tick(); tick(); tick();
        chk("st_before_limit", 32'(bus.host_starved), 32'd0);
        tick();
        chk("st_at_limit", 32'(bus.host_starved), 32'd1);
        tick(); tick();
        bus.cpu_RE = 1'b0;
        #1;
        chk("st_ready", 32'(bus.host_ready), 32'd1);
        tick();
        bus.host_valid = 1'b0;
        chk("st_sticky", 32'(bus.host_starved), 32'd1);
        chk("st_wait_max", 32'(bus.host_wait_max), 32'd6);
        chk("st_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("st_rdata", bus.host_rdata, 32'hDEAD_BEEF);
        tick();

        // Back-to-back reads
        bus.host_valid = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = 32'h0;
        tick();
        bus.host_addr = 32'h4;
        #1;
        chk("bb_ready2", 32'(bus.host_ready), 32'd1);
        chk("bb_rvalid1", 32'(bus.host_rvalid), 32'd1);
        chk("bb_rdata1", bus.host_rdata, 32'h1111_1111);
        tick();
        bus.host_valid = 1'b0;
        chk("bb_rvalid2", 32'(bus.host_rvalid), 32'd1);
        chk("bb_rdata2", bus.host_rdata, 32'h2222_2222);
        tick();
        chk("bb_rvalid_end", 32'(bus.host_rvalid), 32'd0);

        // Reset right after a read accept
        bus.host_valid = 1'b1;
        bus.host_addr  = 32'h10;
        tick();
        bus.host_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("mr_rdata", bus.host_rdata, 32'h0);
        chk("mr_wait_max", 32'(bus.host_wait_max), 32'd0);
        chk("mr_starved", 32'(bus.host_starved), 32'd0);

        // Host withdraws while blocked: count discarded
        bus.cpu_RE     = 1'b1;
        bus.cpu_A      = 32'h48;
        bus.host_valid = 1'b1;
        bus.host_addr  = 32'h4;
        tick(); tick();
        bus.host_valid = 1'b0;
        tick();
        bus.cpu_RE     = 1'b0;
        bus.host_valid = 1'b1;
        tick();
        bus.host_valid = 1'b0;
        chk("wd_wait_max", 32'(bus.host_wait_max), 32'd0);
        chk("wd_rdata", bus.host_rdata, 32'h2222_2222);
        tick();

        // Core write passthrough with host idle
        bus.cpu_WE    = 1'b1;
        bus.cpu_A     = 32'h8;
        bus.cpu_wdata = 32'h7;
        #1;
        chk("cpw_mem_WE", 32'(bus.mem_WE), 32'd1);
        chk("cpw_mem_RE", 32'(bus.mem_RE), 32'd0);
        chk("cpw_mem_A", bus.mem_A, 32'h8);
        chk("cpw_mem_wdata", bus.mem_wdata, 32'h7);
        chk("cpw_host_ready", 32'(bus.host_ready), 32'd0);
        tick();
        idle_inputs();
        bus.cpu_RE = 1'b1;
        bus.cpu_A  = 32'h8;
        #1;
        chk("cpw_cpu_rdata", bus.cpu_rdata, 32'h7);
        tick();
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
